// File: rtl/lap_stopwatch_pkg.sv
// Shared definitions for the lap stopwatch slice.
// Contents: FSM state type, time-field widths, radix limits, the packed
// time/lap record and helpers that convert between a time record and a
// stored lap word.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } sw_state_t;

    localparam int HOUR_W = 7;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CS_W   = 7;
    localparam int LAP_W  = HOUR_W + MIN_W + SEC_W + CS_W;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Field order matches the stored lap layout {h, m, s, cs}.
    typedef struct packed {
        logic [HOUR_W-1:0] h;
        logic [MIN_W-1:0]  m;
        logic [SEC_W-1:0]  s;
        logic [CS_W-1:0]   cs;
    } sw_time_t;

    function automatic logic [LAP_W-1:0] pack_lap(input sw_time_t t);
        return t;
    endfunction

    function automatic sw_time_t unpack_lap(input logic [LAP_W-1:0] w);
        return w;
    endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Button/display bundle of the lap stopwatch.
// master: the button/selector side (debouncers, board logic) driving the
//         controls and reading the display fields and lap status.
// slave:  the stopwatch itself.
// Controls: start_pause, lap, reset, clear, view_lap, lap_sel.
// Status:   hour, minute, second, m_sec, running, lap_count, lap_full,
//           lap_valid.
interface lap_stopwatch_if
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 8
) ();

    localparam int SEL_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);

    logic             start_pause;
    logic             lap;
    logic             reset;
    logic             clear;
    logic             view_lap;
    logic [SEL_W-1:0] lap_sel;

    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [CS_W-1:0]   m_sec;
    logic              running;
    logic [CNT_W-1:0]  lap_count;
    logic              lap_full;
    logic              lap_valid;

    modport master (
        output start_pause, lap, reset, clear, view_lap, lap_sel,
        input  hour, minute, second, m_sec, running, lap_count, lap_full, lap_valid
    );

    modport slave (
        input  start_pause, lap, reset, clear, view_lap, lap_sel,
        output hour, minute, second, m_sec, running, lap_count, lap_full, lap_valid
    );

endinterface

// File: rtl/lap_stopwatch_time.sv
// time_counter: clock prescaler plus cascaded HH:MM:SS.cc counter.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   run            : advance the prescaler (FSM is RUNNING)
//   zero           : return prescaler and time to zero
//   tick           : high on the edge where the centisecond advances
//   now            : current time value
// The prescaler holds while run is low so a pause keeps a partial tick.
module time_counter
    import stopwatch_pkg::*;
#(
    parameter int DIV       = 500000,
    parameter int HOUR_WRAP = 100
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     run,
    input  logic     zero,
    output logic     tick,
    output sw_time_t now
);

    localparam int PS_W = $clog2(DIV);

    logic [PS_W-1:0] presc;
    sw_time_t        t_q;
    sw_time_t        t_next;

    assign tick = run && (presc == PS_W'(DIV - 1));
    assign now  = t_q;

    always_comb begin
        t_next = t_q;
        if (t_q.cs != CS_W'(CS_MAX)) begin
            t_next.cs = t_q.cs + CS_W'(1);
        end else begin
            t_next.cs = '0;
            if (t_q.s != SEC_W'(SEC_MAX)) begin
                t_next.s = t_q.s + SEC_W'(1);
            end else begin
                t_next.s = '0;
                if (t_q.m != MIN_W'(MIN_MAX)) begin
                    t_next.m = t_q.m + MIN_W'(1);
                end else begin
                    t_next.m = '0;
                    t_next.h = (t_q.h == HOUR_W'(HOUR_WRAP - 1)) ? '0 : t_q.h + HOUR_W'(1);
                end
            end
        end
    end

    // Time is only written on a tick or a zero so it is otherwise left alone.
    always_ff @(posedge clock) begin
        if (!reset_n || zero) begin
            presc <= '0;
            t_q   <= '0;
        end else if (run) begin
            if (tick) begin
                presc <= '0;
                t_q   <= t_next;
            end else begin
                presc <= presc + PS_W'(1);
            end
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: run/pause/reset key FSM, time counter and lap buffer.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   sw (slave)     : debounced button levels, display select, display
//                    fields (registered), running, lap_count, lap_full,
//                    lap_valid
// Button events are one-cycle pulses after a registered 0->1 transition.
// Laps live in a circular buffer; the newest entry sits just below wr_ptr.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int TICK_HZ       = 100,
    parameter int HOUR_WRAP     = 100,
    parameter int LAP_DEPTH     = 8,
    parameter int LAP_OVERWRITE = 0
) (
    input logic            clock,
    input logic            reset_n,
    lap_stopwatch_if.slave sw
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);

    // ---------------- edge detect ----------------
    // Bit order: {clear, reset, lap, start_pause}.
    logic [3:0] btn_raw;
    logic [3:0] btn_q;
    logic [3:0] btn_prev;
    logic [3:0] btn_ev;

    assign btn_raw = {sw.clear, sw.reset, sw.lap, sw.start_pause};
    assign btn_ev  = btn_q & ~btn_prev;

    // History resets high so a button held through reset stays silent.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            btn_q    <= '1;
            btn_prev <= '1;
        end else begin
            btn_q    <= btn_raw;
            btn_prev <= btn_q;
        end
    end

    logic sp_ev, lap_ev, rst_ev, clr_ev;
    assign sp_ev  = btn_ev[0];
    assign lap_ev = btn_ev[1];
    assign rst_ev = btn_ev[2];
    assign clr_ev = btn_ev[3];

    // ---------------- FSM ----------------
    sw_state_t state;
    logic      running_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sp_ev) begin
                        state     <= ST_RUNNING;
                        running_q <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (sp_ev) begin
                        state     <= ST_PAUSED;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (rst_ev) begin
                        state     <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (sp_ev) begin
                        state     <= ST_RUNNING;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- time counter ----------------
    logic     run;
    logic     zero;
    logic     tick_unused;
    sw_time_t now;

    assign run  = (state == ST_RUNNING);
    assign zero = (state == ST_PAUSED) && rst_ev;

    time_counter #(
        .DIV       (DIV),
        .HOUR_WRAP (HOUR_WRAP)
    ) u_tc (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run),
        .zero    (zero),
        .tick    (tick_unused),
        .now     (now)
    );

    // ---------------- lap buffer ----------------
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] lap_count_q;
    logic [LAP_W-1:0] lap_mem [LAP_DEPTH];
    logic             full;
    logic             valid;
    logic             cap_ev;
    logic             wr_en;
    logic [PTR_W-1:0] rd_idx;

    assign full     = (lap_count_q == CNT_W'(LAP_DEPTH));
    assign valid    = (CNT_W'(sw.lap_sel) < lap_count_q);
    // `now` is the pre-edge time, so a tick on the same edge is not seen.
    assign cap_ev   = lap_ev && (state == ST_RUNNING) && !clr_ev;
    assign wr_en    = cap_ev && (!full || (LAP_OVERWRITE != 0));
    assign ptr_next = (wr_ptr == PTR_W'(LAP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);

    // Offset by 2*LAP_DEPTH keeps the modulo operand non-negative for any lap_sel.
    always_comb begin
        rd_idx = PTR_W'((int'(wr_ptr) + 2 * LAP_DEPTH - 1 - int'(sw.lap_sel)) % LAP_DEPTH);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            lap_count_q <= '0;
        end else if (clr_ev) begin
            wr_ptr      <= '0;
            lap_count_q <= '0;
        end else if (wr_en) begin
            wr_ptr <= ptr_next;
            if (!full) begin
                lap_count_q <= lap_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            lap_mem[wr_ptr] <= pack_lap(now);
        end
    end

    // ---------------- display mux ----------------
    sw_time_t disp_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            disp_q <= '0;
        end else if (!sw.view_lap) begin
            disp_q <= now;
        end else if (valid) begin
            disp_q <= unpack_lap(lap_mem[rd_idx]);
        end else begin
            disp_q <= '0;
        end
    end

    assign sw.hour      = disp_q.h;
    assign sw.minute    = disp_q.m;
    assign sw.second    = disp_q.s;
    assign sw.m_sec     = disp_q.cs;
    assign sw.running   = running_q;
    assign sw.lap_count = lap_count_q;
    assign sw.lap_full  = full;
    assign sw.lap_valid = valid;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (lap drop / lap overwrite) share
// one stimulus stream. A reference model keeps time as a plain centisecond
// total and laps as queues; it is compared with both instances every cycle.
// Directed sequences and a vector table add hand-derived expectations.
module tb_lap_stopwatch;
    import stopwatch_pkg::*;

    localparam int DEPTH   = 4;
    localparam int DIVV    = 10;
    localparam int WRAP    = 100;
    localparam int WRAP_CS = WRAP * 360000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       sp = 1'b0, lp = 1'b0, rs = 1'b0, cl = 1'b0, vw = 1'b0;
    logic [1:0] sel = 2'd0;

    lap_stopwatch_if #(.LAP_DEPTH(DEPTH)) bus0 ();
    lap_stopwatch_if #(.LAP_DEPTH(DEPTH)) bus1 ();

    assign bus0.start_pause = sp;  assign bus1.start_pause = sp;
    assign bus0.lap = lp;          assign bus1.lap = lp;
    assign bus0.reset = rs;        assign bus1.reset = rs;
    assign bus0.clear = cl;        assign bus1.clear = cl;
    assign bus0.view_lap = vw;     assign bus1.view_lap = vw;
    assign bus0.lap_sel = sel;     assign bus1.lap_sel = sel;

    lap_stopwatch #(
        .CLK_HZ(1000), .TICK_HZ(100), .HOUR_WRAP(WRAP), .LAP_DEPTH(DEPTH), .LAP_OVERWRITE(0)
    ) dut0 (.clock(clock), .reset_n(reset_n), .sw(bus0.slave));

    lap_stopwatch #(
        .CLK_HZ(1000), .TICK_HZ(100), .HOUR_WRAP(WRAP), .LAP_DEPTH(DEPTH), .LAP_OVERWRITE(1)
    ) dut1 (.clock(clock), .reset_n(reset_n), .sw(bus1.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 running, 2 paused
    int m_state = 0, m_tot = 0, m_presc = 0;
    int q0[$], q1[$];
    int disp0 = 0, disp1 = 0;
    bit hq[4] = '{1, 1, 1, 1};
    bit hp[4] = '{1, 1, 1, 1};

    function automatic int lap_pick(input int q[$], input int s);
        if (s < q.size()) return q[q.size() - 1 - s];
        return 0;
    endfunction

    task automatic model_edge();
        bit in[4];
        bit ev[4];
        int nxt;
        bit was_run;
        in = '{sp, lp, rs, cl};
        if (!reset_n) begin
            m_state = 0; m_tot = 0; m_presc = 0;
            q0.delete(); q1.delete();
            disp0 = 0; disp1 = 0;
            hq = '{1, 1, 1, 1}; hp = '{1, 1, 1, 1};
            return;
        end
        for (int i = 0; i < 4; i++) ev[i] = hq[i] && !hp[i];
        disp0 = vw ? lap_pick(q0, int'(sel)) : m_tot;
        disp1 = vw ? lap_pick(q1, int'(sel)) : m_tot;
        if (ev[3]) begin
            q0.delete(); q1.delete();
        end else if (ev[1] && m_state == 1) begin
            if (q0.size() < DEPTH) q0.push_back(m_tot);
            if (q1.size() == DEPTH) void'(q1.pop_front());
            q1.push_back(m_tot);
        end
        was_run = (m_state == 1);
        nxt = m_state;
        if (m_state == 2 && ev[2]) nxt = 0;
        else if (ev[0]) nxt = (m_state == 1) ? 2 : 1;
        if (was_run) begin
            if (m_presc == DIVV - 1) begin
                m_presc = 0;
                m_tot = (m_tot + 1) % WRAP_CS;
            end else begin
                m_presc++;
            end
        end
        if (m_state == 2 && ev[2]) begin
            m_tot = 0; m_presc = 0;
        end
        m_state = nxt;
        hp = hq;
        hq = in;
    endtask

    task automatic chk_dut(input string t, input int hr, input int mn, input int sc, input int cs,
                           input int run, input int cnt, input int full, input int vld,
                           input int disp, input int qs);
        chk({t, "_hour"},   hr,  disp / 360000);
        chk({t, "_minute"}, mn,  (disp / 6000) % 60);
        chk({t, "_second"}, sc,  (disp / 100) % 60);
        chk({t, "_msec"},   cs,  disp % 100);
        chk({t, "_running"}, run, (m_state == 1) ? 1 : 0);
        chk({t, "_count"},  cnt, qs);
        chk({t, "_full"},   full, (qs == DEPTH) ? 1 : 0);
        chk({t, "_valid"},  vld, (int'(sel) < qs) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk_dut("d0", bus0.hour, bus0.minute, bus0.second, bus0.m_sec, bus0.running,
                bus0.lap_count, bus0.lap_full, bus0.lap_valid, disp0, q0.size());
        chk_dut("d1", bus1.hour, bus1.minute, bus1.second, bus1.m_sec, bus1.running,
                bus1.lap_count, bus1.lap_full, bus1.lap_valid, disp1, q1.size());
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: sp = v;
            1: lp = v;
            2: rs = v;
            default: cl = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        step();
        set_btn(b, 1'b0);
        step();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    // edges counted since the FSM entered RUNNING in the lap sequence
    int c = 0;

    task automatic lap_at(input int target);
        while (c < target - 1) begin
            step();
            c++;
        end
        press(1);
        c += 2;
    endtask

    typedef struct {
        logic       view;
        logic [1:0] s;
        int         exp0;
        int         exp1;
    } vec_t;

    sw_time_t preload;

    initial begin
        vec_t vt[5];
        int hold;
        int b;

        // ---------------- reset ----------------
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rst_hour", bus0.hour, 0);
        chk("rst_msec", bus0.m_sec, 0);
        chk("rst_running", bus0.running, 0);
        chk("rst_count", bus1.lap_count, 0);

        // ---------------- first ticks ----------------
        press(0);
        chk("start_running", bus0.running, 1);
        repeat (10) step();
        chk("tick10_display_lags", bus0.m_sec, 0);
        step();
        chk("tick10_msec", bus0.m_sec, 1);
        repeat (990) step();
        chk("one_sec_second", bus0.second, 1);
        chk("one_sec_msec", bus0.m_sec, 0);

        // ---------------- pause keeps partial tick ----------------
        pulse_reset();
        press(0);
        repeat (253) step();
        press(0);
        repeat (50) step();
        chk("paused_msec", bus0.m_sec, 25);
        chk("paused_running", bus0.running, 0);
        press(0);
        repeat (5) step();
        chk("resume_pre_tick", bus0.m_sec, 25);
        step();
        chk("resume_tick", bus0.m_sec, 26);

        // ---------------- reset key ----------------
        press(2);
        chk("rst_ignored_running", bus0.running, 1);
        press(0);
        press(2);
        step();
        chk("rst_paused_running", bus0.running, 0);
        chk("rst_paused_msec", bus0.m_sec, 0);
        chk("rst_paused_second", bus0.second, 0);

        // ---------------- full wrap ----------------
        preload = '{h: 7'd99, m: 6'd59, s: 6'd59, cs: 7'd99};
        force dut0.u_tc.t_q = preload;
        force dut1.u_tc.t_q = preload;
        m_tot = WRAP_CS - 1;
        step();
        release dut0.u_tc.t_q;
        release dut1.u_tc.t_q;
        chk("preload_hour", bus0.hour, 99);
        press(0);
        repeat (10) step();
        chk("wrap_pre_minute", bus1.minute, 59);
        step();
        chk("wrap_hour", bus0.hour, 0);
        chk("wrap_minute", bus0.minute, 0);
        chk("wrap_second", bus0.second, 0);
        chk("wrap_msec", bus0.m_sec, 0);
        chk("wrap_running", bus0.running, 1);

        // ---------------- five laps ----------------
        pulse_reset();
        press(0);
        c = 0;
        lap_at(35);
        lap_at(72);
        lap_at(125);
        lap_at(200);
        lap_at(311);
        chk("laps_count_drop", bus0.lap_count, 4);
        chk("laps_full_drop", bus0.lap_full, 1);
        chk("laps_count_ovw", bus1.lap_count, 4);
        chk("laps_full_ovw", bus1.lap_full, 1);
        press(0);

        vt[0] = '{view: 1'b1, s: 2'd0, exp0: 20, exp1: 31};
        vt[1] = '{view: 1'b1, s: 2'd1, exp0: 12, exp1: 20};
        vt[2] = '{view: 1'b1, s: 2'd2, exp0: 7,  exp1: 12};
        vt[3] = '{view: 1'b1, s: 2'd3, exp0: 3,  exp1: 7};
        vt[4] = '{view: 1'b0, s: 2'd0, exp0: 31, exp1: 31};
        for (int i = 0; i < 5; i++) begin
            vw = vt[i].view;
            sel = vt[i].s;
            step();
            chk($sformatf("vec%0d_d0_msec", i), bus0.m_sec, vt[i].exp0);
            chk($sformatf("vec%0d_d1_msec", i), bus1.m_sec, vt[i].exp1);
            chk($sformatf("vec%0d_d1_second", i), bus1.second, 0);
        end
        vw = 1'b0;
        sel = 2'd0;

        // ---------------- same-cycle events ----------------
        press(3);
        chk("clear_count", bus0.lap_count, 0);
        press(0);
        repeat (20) step();
        sp = 1'b1; lp = 1'b1;
        step();
        sp = 1'b0; lp = 1'b0;
        step();
        chk("sp_lap_running", bus0.running, 0);
        chk("sp_lap_count", bus0.lap_count, 1);
        press(0);
        cl = 1'b1; lp = 1'b1;
        step();
        cl = 1'b0; lp = 1'b0;
        step();
        chk("clr_lap_count", bus1.lap_count, 0);
        chk("clr_lap_running", bus1.running, 1);
        press(0);
        press(1);
        chk("paused_lap_count", bus0.lap_count, 0);

        // ---------------- held buttons ----------------
        sp = 1'b1; lp = 1'b1;
        repeat (3) step();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("held_sp_through_rst", bus0.running, 0);
        sp = 1'b0;
        repeat (2) step();
        chk("held_sp_release", bus0.running, 0);
        press(0);
        chk("after_held_start", bus0.running, 1);
        repeat (3) step();
        lp = 1'b0;
        repeat (3) step();
        chk("held_lap_through_rst", bus0.lap_count, 0);
        sp = 1'b1;
        repeat (100) step();
        chk("hold_sp_one_toggle", bus0.running, 0);
        sp = 1'b0;
        repeat (3) step();
        chk("hold_sp_after_release", bus0.running, 0);

        // ---------------- random ----------------
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold > 0) begin
                hold--;
            end else begin
                sp = 1'b0; lp = 1'b0; rs = 1'b0; cl = 1'b0;
                if ($urandom_range(0, 5) == 0) begin
                    b = $urandom_range(0, 5);
                    case (b)
                        0, 1: set_btn(0, 1'b1);
                        2, 3: set_btn(1, 1'b1);
                        4: set_btn(2, 1'b1);
                        default: set_btn(3, 1'b1);
                    endcase
                    hold = $urandom_range(1, 4);
                end
            end
            vw = ($urandom_range(0, 2) == 0);
            sel = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
